// File: rtl/count_hex_uart_pkg.sv
// Shared types and helpers for the count-to-hex UART observer.
package count_hex_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BITS = 10;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/count_fifo.sv
// Small synchronous FIFO; pointers carry a wrap bit to separate full from empty.
module count_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only read when the pointers say it is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/count_hex_uart.sv
// Samples the upstream 4-bit count periodically and sends each sample as an
// ASCII hex character on an 8N1 UART line.
module count_hex_uart
    import count_hex_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 87,
    parameter int SAMPLE_PERIOD = 10000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [3:0] count_i,
    input  logic       enable_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       overflow_o,
    output logic       tx_oeb_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);

    tx_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;

    logic        strobe, push, pop, full, empty, bit_done;
    logic [3:0]  fifo_dout;

    count_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (count_i),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty)
    );

    // Fullness is judged before any same-cycle pop, so a full queue always drops.
    assign strobe   = enable_i && (timer_q == TIMER_LAST);
    assign push     = strobe && !full;
    assign timer_d  = (!enable_i || strobe) ? '0 : timer_q + 1'b1;
    assign ovf_d    = ovf_q | (strobe & full);
    assign bit_done = (clk_cnt_q == BIT_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = '0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    shift_d = nibble_to_ascii(fifo_dout);
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level is registered from the next state so tx_o tracks state_q exactly.
    always_comb begin
        pop    = (state_q == IDLE) && !empty;
        busy_d = (state_d != IDLE) || push || !empty;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign tx_oeb_o   = 1'b0;

endmodule

// File: tb/tb_count_hex_uart.sv
// Bench for count_hex_uart: two instances (slow and fast sampling) compared
// every cycle against a frame-level reference model.
module tb_count_hex_uart;
    import count_hex_uart_pkg::FRAME_BITS;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk;
    logic       rst_a, en_a, tx_a, busy_a, ovf_a, oeb_a;
    logic       rst_b, en_b, tx_b, busy_b, ovf_b, oeb_b;
    logic [3:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         sel;
    int         sp;
    int         t;
    int         q[$];
    int         timer_m;
    int         frame_start;
    int         frame_end;
    logic [7:0] cur_byte;
    logic       ovf_m;

    count_hex_uart #(.CLKS_PER_BIT(CPB), .SAMPLE_PERIOD(50), .FIFO_DEPTH(DEPTH)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst_a), .count_i(cnt_a), .enable_i(en_a),
        .tx_o(tx_a), .busy_o(busy_a), .overflow_o(ovf_a), .tx_oeb_o(oeb_a)
    );

    count_hex_uart #(.CLKS_PER_BIT(CPB), .SAMPLE_PERIOD(5), .FIFO_DEPTH(DEPTH)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst_b), .count_i(cnt_b), .enable_i(en_b),
        .tx_o(tx_b), .busy_o(busy_b), .overflow_o(ovf_b), .tx_oeb_o(oeb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] hex_char(input int n);
        if (n < 10) return 8'(48 + n);   // '0' + n
        return 8'(65 + n - 10);          // 'A' + n - 10
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (dut %0d, cycle %0d)", tag, obs, exp, sel, t);
        end
    endtask

    task automatic model_reset();
        q.delete();
        timer_m     = 0;
        frame_start = 0;
        frame_end   = -1;
        cur_byte    = 8'h00;
        ovf_m       = 1'b0;
    endtask

    task automatic select(input int s);
        sel = s;
        sp  = (s == 0) ? 50 : 5;
        model_reset();
    endtask

    task automatic observe(output logic o_tx, output logic o_busy, output logic o_ovf, output logic o_oeb);
        if (sel == 0) begin
            o_tx = tx_a; o_busy = busy_a; o_ovf = ovf_a; o_oeb = oeb_a;
        end else begin
            o_tx = tx_b; o_busy = busy_b; o_ovf = ovf_b; o_oeb = oeb_b;
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic cycle(input logic rst, input logic en, input logic [3:0] cnt);
        logic o_tx, o_busy, o_ovf, o_oeb;
        logic e_tx, e_busy;
        logic do_pop, strobe, full;
        int   idx;
        @(negedge clk);
        if (t <= frame_end) begin
            idx  = (t - frame_start) / CPB;
            e_tx = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : cur_byte[idx-1];
        end else begin
            e_tx = 1'b1;
        end
        e_busy = (t <= frame_end) || (q.size() > 0);
        observe(o_tx, o_busy, o_ovf, o_oeb);
        chk("tx", o_tx, e_tx);
        chk("busy", o_busy, e_busy);
        chk("overflow", o_ovf, ovf_m);
        chk("tx_oeb", o_oeb, 1'b0);

        if (sel == 0) begin
            rst_a = rst; en_a = en; cnt_a = cnt; rst_b = 1'b1; en_b = 1'b0;
        end else begin
            rst_b = rst; en_b = en; cnt_b = cnt; rst_a = 1'b1; en_a = 1'b0;
        end

        if (rst) begin
            #1;
            observe(o_tx, o_busy, o_ovf, o_oeb);
            chk("rst_tx", o_tx, 1'b1);
            chk("rst_busy", o_busy, 1'b0);
            chk("rst_overflow", o_ovf, 1'b0);
            model_reset();
        end else begin
            do_pop  = (t > frame_end) && (q.size() > 0);
            strobe  = en && (timer_m == sp - 1);
            full    = (q.size() == DEPTH);
            timer_m = (!en || strobe) ? 0 : timer_m + 1;
            if (do_pop) begin
                cur_byte    = hex_char(q.pop_front());
                frame_start = t + 1;
                frame_end   = t + FRAME;
            end
            if (strobe) begin
                if (full) ovf_m = 1'b1;
                else      q.push_back(int'(cnt));
            end
        end
        t++;
    endtask

    initial begin
        bit hit;
        int len;
        logic en_r;
        rst_a = 1'b1; en_a = 1'b0; cnt_a = 4'h0;
        rst_b = 1'b1; en_b = 1'b0; cnt_b = 4'h0;
        t = 0;
        select(0);

        // reset with random inputs, then release idle
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 4'($urandom));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // count 5 -> '5' (0x35), then count B -> 'B' (0x42)
        for (int i = 0; i < 95; i++) cycle(1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b0, 4'h5);
        for (int i = 0; i < 95; i++) cycle(1'b0, 1'b1, 4'hB);
        for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b0, 4'hB);

        // reset during DATA bit 3, then a clean frame after release
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (t <= frame_end && (t - frame_start) == 17) begin
                hit = 1'b1;
                break;
            end
            cycle(1'b0, 1'b1, 4'($urandom_range(0, 7)));
        end
        checks++;
        if (!hit) begin
            errors++;
            $error("FAIL reach_data_bit3: observed=timeout expected=frame within 200 cycles");
        end
        for (int i = 0; i < 3; i++)   cycle(1'b1, 1'b1, 4'h3);
        for (int i = 0; i < 110; i++) cycle(1'b0, 1'b1, 4'($urandom));
        for (int i = 0; i < 50; i++)  cycle(1'b0, 1'b0, 4'h0);

        // random enable phases on the slow instance
        for (int p = 0; p < 5; p++) begin
            len  = $urandom_range(20, 150);
            en_r = 1'($urandom);
            for (int i = 0; i < len; i++) cycle(1'b0, en_r, 4'($urandom));
        end

        // fast instance: stepping counts overrun the queue
        select(1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 4'($urandom));
        for (int k = 0; k < 300; k++) cycle(1'b0, 1'b1, 4'(k / 5));
        chk("overflow_set", ovf_b, 1'b1);
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0, 4'h0);
        chk("overflow_sticky", ovf_b, 1'b1);
        chk("drained_busy", busy_b, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 4'h0);

        // two strobes queued, then enable dropped
        for (int i = 0; i < 10; i++)  cycle(1'b0, 1'b1, 4'($urandom));
        for (int i = 0; i < 120; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // random phases with occasional resets
        for (int p = 0; p < 8; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 4'h0);
            end
            len  = $urandom_range(10, 120);
            en_r = 1'($urandom);
            for (int i = 0; i < len; i++) cycle(1'b0, en_r, 4'($urandom));
        end
        for (int i = 0; i < 220; i++) cycle(1'b0, 1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
